// File: rtl/video_stream_pkg.sv
// ============================================================================
// Module      : video_stream_pkg
// Description : Shared types and constants for the pixel stream receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_stream_pkg;

  localparam int DEFAULT_H_RES = 640;
  localparam int DEFAULT_V_RES = 480;

  localparam int ERR_SOF = 0;
  localparam int ERR_EOL = 1;

  typedef logic [23:0] pixel_t;

  typedef struct packed {
    logic   tuser;
    logic   tlast;
    pixel_t pixel;
  } rx_word_t;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_rx_fifo.sv
// ============================================================================
// Module      : pixel_rx_fifo
// Description : First-word-fall-through synchronous FIFO of rx_word_t.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_rx_fifo
  import video_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  rx_word_t               wr_data,
  input  logic                   pop,
  output rx_word_t               rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rx_word_t           mem_q [DEPTH];
  rx_word_t           mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_stream_receiver.sv
// ============================================================================
// Module      : pixel_stream_receiver
// Description : Checks ray-marcher pixels against frame geometry, buffers them
//               and re-emits AXI4-Stream video. RX_STATS_EN adds drop_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_stream_receiver
  import video_stream_pkg::*;
#(
  parameter int H_RES      = DEFAULT_H_RES,
  parameter int V_RES      = DEFAULT_V_RES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic        pix_eol,
  output logic        pix_ready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [1:0]  err_flags,
  input  logic        err_clr
`ifdef RX_STATS_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rx_state_t        state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [1:0]       err_q, err_d;

  logic             accept, push, sof_set, eol_set, frame_end, dropped;
  logic             x_last, y_last, at_origin;
  rx_word_t         wr_word, rd_word;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Ready looks only at the registered occupancy so it never depends on tready.
  assign pix_ready = !rst && (fifo_count != CNT_W'(FIFO_DEPTH));
  assign accept    = pix_valid && pix_ready;
  assign x_last    = (x_q == X_W'(H_RES - 1));
  assign y_last    = (y_q == Y_W'(V_RES - 1));
  assign at_origin = (x_q == '0) && (y_q == '0);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    push    = 1'b0;
    wr_word = '{tuser: 1'b0, tlast: 1'b0, pixel: pix_data};
    sof_set = 1'b0;
    eol_set = 1'b0;
    frame_end = 1'b0;
    dropped = 1'b0;
    if (accept) begin
      case (state_q)
        WAIT_SOF: begin
          if (pix_sof) begin
            push          = 1'b1;
            wr_word.tuser = 1'b1;
            x_d           = X_W'(1);
            y_d           = '0;
            state_d       = ACTIVE;
          end else begin
            dropped = 1'b1;
          end
        end
        ACTIVE: begin
          if (pix_sof && !at_origin) begin
            // Early sof: resync as a fresh (0,0), which is never a line end.
            sof_set       = 1'b1;
            eol_set       = pix_eol;
            push          = 1'b1;
            wr_word.tuser = 1'b1;
            x_d           = X_W'(1);
            y_d           = '0;
          end else if (!pix_sof && at_origin) begin
            sof_set = 1'b1;
            state_d = WAIT_SOF;
          end else begin
            push          = 1'b1;
            wr_word.tuser = at_origin;
            wr_word.tlast = x_last;
            eol_set       = (pix_eol != x_last);
            if (x_last) begin
              x_d = '0;
              if (y_last) begin
                y_d       = '0;
                frame_end = 1'b1;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end

    frame_done_d  = frame_end;
    frame_count_d = frame_count_q + {15'd0, frame_end};
    err_d         = err_clr ? 2'b00 : err_q;
    err_d[ERR_SOF] = err_d[ERR_SOF] | sof_set;
    err_d[ERR_EOL] = err_d[ERR_EOL] | eol_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_SOF;
      x_q           <= '0;
      y_q           <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

`ifdef RX_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = err_clr ? 16'd0 : drop_count_q;
    if (dropped && (drop_count_d != 16'hFFFF)) begin
      drop_count_d = drop_count_d + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

  pixel_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push && !fifo_full),
    .wr_data (wr_word),
    .pop     (m_axis_tready),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 32'd0 : {8'h00, rd_word.pixel};
  assign m_axis_tuser  = !fifo_empty && rd_word.tuser;
  assign m_axis_tlast  = !fifo_empty && rd_word.tlast;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
  assign err_flags     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_receiver.sv
// ============================================================================
// Module      : tb_pixel_stream_receiver
// Description : Directed self-checking bench, H_RES=4 V_RES=2 FIFO_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_stream_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic        pix_eol = 1'b0;
  logic        pix_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [1:0]  err_flags;
  logic        err_clr = 1'b0;
`ifdef RX_STATS_EN
  logic [15:0] drop_count;
`endif

  int tests  = 0;
  int failed = 0;
  int done_pulses = 0;
  logic [33:0] beats[$];

  pixel_stream_receiver #(
    .H_RES      (4),
    .V_RES      (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .pix_ready     (pix_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .err_flags     (err_flags),
    .err_clr       (err_clr)
`ifdef RX_STATS_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Records every handshaken beat as {tuser, tlast, tdata}.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready)
      beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (!rst && frame_done)
      done_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    logic ok = 1'b0;
    @(posedge clk); #1;
    pix_data = d; pix_sof = s; pix_eol = e; pix_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (pix_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    chk("send_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic u, input logic l);
    logic [33:0] got = 'x;
    for (int w = 0; w < 50 && beats.size() == 0; w++) @(negedge clk);
    if (beats.size() != 0) got = beats.pop_front();
    chk(tag, {30'd0, got}, {30'd0, u, l, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    logic acc;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  {63'd0, pix_ready}, 64'd0);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata",  {32'd0, m_axis_tdata}, 64'd0);
    chk("rst_tuser_tlast", {62'd0, m_axis_tuser, m_axis_tlast}, 64'd0);
    chk("rst_fcount", {48'd0, frame_count}, 64'd0);
    chk("rst_err",    {62'd0, err_flags}, 64'd0);
    chk("rst_fdone",  {63'd0, frame_done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- nominal frame ----------------
    send(24'h000001, 1'b1, 1'b0);
    @(negedge clk);
    chk("latency_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("latency_tdata",  {32'd0, m_axis_tdata}, 64'h1);
    for (int i = 2; i <= 8; i++) send(24'(i), 1'b0, (i == 4) || (i == 8));
    for (int i = 1; i <= 8; i++)
      expect_beat("nom_beat", 32'(i), i == 1, (i == 4) || (i == 8));
    idle(3);
    @(negedge clk);
    chk("nom_fdone_pulses", 64'(done_pulses), 64'd1);
    chk("nom_fcount", {48'd0, frame_count}, 64'd1);
    chk("nom_err", {62'd0, err_flags}, 64'd0);

    // ---------------- backpressure ----------------
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      pix_valid = 1'b1; pix_data = 24'(idx + 1);
      pix_sof = (idx == 0); pix_eol = (idx == 3);
      @(negedge clk); acc = pix_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 64'(idx), 64'd4);
    chk("bp_ready_low", {63'd0, pix_ready}, 64'd0);
    chk("bp_hold_tdata", {32'd0, m_axis_tdata}, 64'h1);
    chk("bp_hold_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      pix_valid = 1'b1; pix_data = 24'(idx + 1);
      pix_sof = 1'b0; pix_eol = (idx == 3);
      @(negedge clk); acc = pix_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    pix_valid = 1'b0; pix_eol = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd6);
    send(24'h000007, 1'b0, 1'b0);
    send(24'h000008, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++)
      expect_beat("bp_beat", 32'(i), i == 1, (i == 4) || (i == 8));
    idle(3);
    chk("bp_fcount", {48'd0, frame_count}, 64'd2);

    // ---------------- reset with pixels buffered ----------------
    m_axis_tready = 1'b0;
    send(24'h0000A1, 1'b1, 1'b0);
    send(24'h0000A2, 1'b0, 1'b0);
    send(24'h0000A3, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("mrst_fcount", {48'd0, frame_count}, 64'd0);
    m_axis_tready = 1'b1;

    // ---------------- start without sof ----------------
    send(24'h0000C1, 1'b0, 1'b0);
    send(24'h0000C2, 1'b0, 1'b0);
    send(24'h0000C3, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    chk("nosof_no_output", 64'(beats.size()), 64'd0);
    chk("nosof_err", {62'd0, err_flags}, 64'd0);
`ifdef RX_STATS_EN
    chk("nosof_drop_count", {48'd0, drop_count}, 64'd3);
`endif
    for (int i = 1; i <= 8; i++) send(24'h000100 + 24'(i), i == 1, (i == 4) || (i == 8));
    for (int i = 1; i <= 8; i++)
      expect_beat("nosof_beat", 32'h100 + 32'(i), i == 1, (i == 4) || (i == 8));
    idle(3);
    chk("nosof_fcount", {48'd0, frame_count}, 64'd1);

    // ---------------- sof mid-line at (2,0) ----------------
    send(24'h000201, 1'b1, 1'b0);
    send(24'h000202, 1'b0, 1'b0);
    send(24'h000203, 1'b1, 1'b0);
    for (int i = 4; i <= 10; i++) send(24'h000200 + 24'(i), 1'b0, (i == 6) || (i == 10));
    expect_beat("sof_b1", 32'h201, 1'b1, 1'b0);
    expect_beat("sof_b2", 32'h202, 1'b0, 1'b0);
    expect_beat("sof_b3", 32'h203, 1'b1, 1'b0);
    for (int i = 4; i <= 10; i++)
      expect_beat("sof_beat", 32'h200 + 32'(i), 1'b0, (i == 6) || (i == 10));
    idle(3);
    chk("sof_err", {62'd0, err_flags}, 64'd1);
    chk("sof_fcount", {48'd0, frame_count}, 64'd2);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("errclr", {62'd0, err_flags}, 64'd0);

    // ---------------- eol on (1,0) ----------------
    for (int i = 1; i <= 8; i++)
      send(24'h000300 + 24'(i), i == 1, (i == 2) || (i == 4) || (i == 8));
    for (int i = 1; i <= 8; i++)
      expect_beat("eol_beat", 32'h300 + 32'(i), i == 1, (i == 4) || (i == 8));
    idle(3);
    @(negedge clk);
    chk("eol_err", {62'd0, err_flags}, 64'd2);
    chk("eol_fcount", {48'd0, frame_count}, 64'd3);
    chk("total_fdone_pulses", 64'(done_pulses), 64'd5);
    chk("no_extra_beats", 64'(beats.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
